// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the arbiter blocks.
package wb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/wb_arb_pick_2.sv
// Combinational two-request picker; returns a one-hot winner (or zero when idle).
module wb_arb_pick_2
  import wb_pkg::*;
#(
  parameter int ARB_ROUND_ROBIN   = ARB_FIXED,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win
);

  // A tie is the only case where the mode matters; round-robin favours the master not granted last.
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01: o_win = 2'b01;
      2'b10: o_win = 2'b10;
      2'b11: begin
        if (ARB_ROUND_ROBIN == ARB_RR) begin
          o_win = i_last ? 2'b01 : 2'b10;
        end else begin
          o_win = (LSB_HIGH_PRIORITY != 0) ? 2'b01 : 2'b10;
        end
      end
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter: registered grant held for the whole CYC,
// combinational forward and return paths with no buffering.
module wb_arbiter_2
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int SELECT_WIDTH      = DATA_WIDTH / 8,
  parameter int ARB_ROUND_ROBIN   = ARB_FIXED,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } grant_e;

  grant_e     r_grant;
  grant_e     w_nextGrant;
  grant_e     w_pickGrant;
  logic       r_last;
  logic       w_nextLast;
  logic [1:0] w_req;
  logic [1:0] w_win;
  logic       w_gnt0;
  logic       w_gnt1;

  assign w_req = {wbm1_cyc_i, wbm0_cyc_i};

  wb_arb_pick_2 #(
    .ARB_ROUND_ROBIN   (ARB_ROUND_ROBIN),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_grant <= w_nextGrant;
      r_last  <= w_nextLast;
    end
  end

  // The grant only moves once the owning master releases CYC, so multi-beat and RMW cycles stay locked.
  always_comb begin
    w_pickGrant = IDLE;
    if (w_win[0]) begin
      w_pickGrant = G0;
    end else if (w_win[1]) begin
      w_pickGrant = G1;
    end

    w_nextGrant = r_grant;
    case (r_grant)
      IDLE:    w_nextGrant = w_pickGrant;
      G0:      if (!w_req[0]) w_nextGrant = w_pickGrant;
      G1:      if (!w_req[1]) w_nextGrant = w_pickGrant;
      default: w_nextGrant = IDLE;
    endcase

    w_nextLast = r_last;
    if (w_nextGrant == G0) begin
      w_nextLast = 1'b0;
    end else if (w_nextGrant == G1) begin
      w_nextLast = 1'b1;
    end
  end

  assign w_gnt0 = (r_grant == G0);
  assign w_gnt1 = (r_grant == G1);

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    case (r_grant)
      G0: begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_sel_o = wbm0_sel_i;
        wbs_we_o  = wbm0_we_i;
        wbs_stb_o = wbm0_stb_i;
        wbs_cyc_o = wbm0_cyc_i;
      end
      G1: begin
        wbs_adr_o = wbm1_adr_i;
        wbs_dat_o = wbm1_dat_i;
        wbs_sel_o = wbm1_sel_i;
        wbs_we_o  = wbm1_we_i;
        wbs_stb_o = wbm1_stb_i;
        wbs_cyc_o = wbm1_cyc_i;
      end
      default: ;
    endcase
  end

  // Read data fans out unqualified; the handshake is what tells a master it is valid.
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

  assign wbm0_ack_o = wbs_ack_i & w_gnt0;
  assign wbm0_err_o = wbs_err_i & w_gnt0;
  assign wbm0_rty_o = wbs_rty_i & w_gnt0;
  assign wbm1_ack_o = wbs_ack_i & w_gnt1;
  assign wbm1_err_o = wbs_err_i & w_gnt1;
  assign wbm1_rty_o = wbs_rty_i & w_gnt1;

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Bench for wb_arbiter_2: a fixed-priority and a round-robin instance share the
// same master stimulus; each has its own combinational slave and response scoreboard.
module tb_wb_arbiter_2;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam logic [AW-1:0] A0 = 32'h0000_0100;
  localparam logic [AW-1:0] A1 = 32'h0000_0200;

  typedef struct packed {
    logic [1:0]    master;
    logic          ack;
    logic          err;
    logic          rty;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  // Shared master-side stimulus
  logic [AW-1:0] m0Adr, m1Adr;
  logic [DW-1:0] m0Dat, m1Dat;
  logic [SW-1:0] m0Sel, m1Sel;
  logic          m0We, m0Stb, m0Cyc, m1We, m1Stb, m1Cyc;

  // Slave behaviour knobs and read data
  logic [DW-1:0] sDat;
  logic          sAck, sErr, sRty;

  // Per-instance outputs (index 0 = fixed priority, 1 = round-robin)
  logic [DW-1:0] m0DatO [2];
  logic [DW-1:0] m1DatO [2];
  logic          m0AckO [2], m0ErrO [2], m0RtyO [2];
  logic          m1AckO [2], m1ErrO [2], m1RtyO [2];
  logic [AW-1:0] sAdr   [2];
  logic [DW-1:0] sDatO  [2];
  logic [SW-1:0] sSel   [2];
  logic          sWe    [2], sStb [2], sCyc [2];
  logic          sAckI  [2], sErrI [2], sRtyI [2];

  resp_t expQ [2][$];
  int    nChecks = 0;
  int    nPass   = 0;
  resp_t monAct, monExp;
  logic  monR0, monR1;

  // Round-robin alternation schedule, one entry per cycle: cyc per master,
  // expected grant (0 idle, 1 m0, 2 m1) and which master gets an ack (-1 none).
  logic [13:0] rrC0 = 14'b00001110111011;
  logic [13:0] rrC1 = 14'b00111011101111;
  int rrGnt [14] = '{0, 1, 1, 2, 2, 1, 1, 2, 2, 1, 1, 2, 2, 0};
  int rrAck [14] = '{-1, 0, -1, 1, -1, 0, -1, 1, -1, 0, -1, 1, -1, -1};

  always #5 clk = ~clk;

  // Two DUTs with a single-cycle combinational slave behind each
  for (genvar g = 0; g < 2; g++) begin : gDut
    assign sAckI[g] = sCyc[g] & sStb[g] & sAck;
    assign sErrI[g] = sCyc[g] & sStb[g] & sErr;
    assign sRtyI[g] = sCyc[g] & sStb[g] & sRty;

    wb_arbiter_2 #(
      .DATA_WIDTH        (DW),
      .ADDR_WIDTH        (AW),
      .SELECT_WIDTH      (SW),
      .ARB_ROUND_ROBIN   (g),
      .LSB_HIGH_PRIORITY (1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .wbm0_adr_i (m0Adr),
      .wbm0_dat_i (m0Dat),
      .wbm0_dat_o (m0DatO[g]),
      .wbm0_we_i  (m0We),
      .wbm0_sel_i (m0Sel),
      .wbm0_stb_i (m0Stb),
      .wbm0_cyc_i (m0Cyc),
      .wbm0_ack_o (m0AckO[g]),
      .wbm0_err_o (m0ErrO[g]),
      .wbm0_rty_o (m0RtyO[g]),
      .wbm1_adr_i (m1Adr),
      .wbm1_dat_i (m1Dat),
      .wbm1_dat_o (m1DatO[g]),
      .wbm1_we_i  (m1We),
      .wbm1_sel_i (m1Sel),
      .wbm1_stb_i (m1Stb),
      .wbm1_cyc_i (m1Cyc),
      .wbm1_ack_o (m1AckO[g]),
      .wbm1_err_o (m1ErrO[g]),
      .wbm1_rty_o (m1RtyO[g]),
      .wbs_adr_o  (sAdr[g]),
      .wbs_dat_i  (sDat),
      .wbs_dat_o  (sDatO[g]),
      .wbs_we_o   (sWe[g]),
      .wbs_sel_o  (sSel[g]),
      .wbs_stb_o  (sStb[g]),
      .wbs_cyc_o  (sCyc[g]),
      .wbs_ack_i  (sAckI[g]),
      .wbs_err_i  (sErrI[g]),
      .wbs_rty_i  (sRtyI[g])
    );
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c0, input logic s0, input logic c1, input logic s1);
    m0Cyc = c0;
    m0Stb = s0;
    m1Cyc = c1;
    m1Stb = s1;
  endtask

  task automatic pushExp(input int g, input int m, input logic a, input logic e, input logic r,
                         input logic [DW-1:0] d);
    resp_t x;
    x.master = 2'(m);
    x.ack    = a;
    x.err    = e;
    x.rty    = r;
    x.data   = d;
    expQ[g].push_back(x);
  endtask

  task automatic pushBoth(input int m, input logic a, input logic e, input logic r, input logic [DW-1:0] d);
    pushExp(0, m, a, e, r, d);
    pushExp(1, m, a, e, r, d);
  endtask

  function automatic logic [AW-1:0] gntAdr(input int code);
    case (code)
      1:       return A0;
      2:       return A1;
      default: return '0;
    endcase
  endfunction

  task automatic checkGrant(input string name, input int g, input int code);
    checkOutput($sformatf("%s.grant%0d", name, g), 64'(sAdr[g]), 64'(gntAdr(code)));
  endtask

  task automatic checkGrantBoth(input string name, input int code);
    checkGrant(name, 0, code);
    checkGrant(name, 1, code);
  endtask

  task automatic checkCycBoth(input string name, input logic exp);
    checkOutput($sformatf("%s.cyc0", name), 64'(sCyc[0]), 64'(exp));
    checkOutput($sformatf("%s.cyc1", name), 64'(sCyc[1]), 64'(exp));
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Response monitor: every cycle a master sees ack/err/rty, pop the next
  // expected response for that instance and compare master, kind and data.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      monR0 = m0AckO[g] | m0ErrO[g] | m0RtyO[g];
      monR1 = m1AckO[g] | m1ErrO[g] | m1RtyO[g];
      if (monR0 | monR1) begin
        monAct.master = (monR0 & monR1) ? 2'd3 : (monR1 ? 2'd1 : 2'd0);
        monAct.ack    = monR1 ? m1AckO[g] : m0AckO[g];
        monAct.err    = monR1 ? m1ErrO[g] : m0ErrO[g];
        monAct.rty    = monR1 ? m1RtyO[g] : m0RtyO[g];
        monAct.data   = monR1 ? m1DatO[g] : m0DatO[g];
        if (expQ[g].size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected_resp%0d: got 0x%0h, expected no response", g, monAct);
        end else begin
          monExp = expQ[g].pop_front();
          checkOutput($sformatf("resp%0d", g), 64'(monAct), 64'(monExp));
        end
      end
    end
  end

  // Watchdog so a broken design can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    m0Adr = A0;            m1Adr = A1;
    m0Dat = 32'h1111_1111; m1Dat = 32'h2222_2222;
    m0Sel = 4'hF;          m1Sel = 4'h3;
    m0We  = 1'b0;          m1We  = 1'b1;
    applyStimulus(0, 0, 0, 0);
    sDat = '0;
    sAck = 1'b1;
    sErr = 1'b0;
    sRty = 1'b0;

    $display("[TB] reset state");
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("reset.bus%0d", g),
                  {sAdr[g], sDatO[g]}, 64'h0);
      checkOutput($sformatf("reset.ctl%0d", g),
                  64'({sSel[g], sWe[g], sStb[g], sCyc[g], m0AckO[g], m1AckO[g]}), 64'h0);
    end
    step();
    rst = 1'b0;

    $display("[TB] single master read");
    applyStimulus(1, 1, 0, 0);
    sDat = 32'hDEAD_BEEF;
    @(negedge clk);
    checkCycBoth("t1.latency", 1'b0);
    step();
    pushBoth(0, 1, 0, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    checkCycBoth("t1.granted", 1'b1);
    checkGrantBoth("t1.granted", 1);
    step();
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkCycBoth("t1.release", 1'b0);
    step();
    @(negedge clk);
    checkGrantBoth("t1.idle", 0);

    $display("[TB] simultaneous requests after reset");
    step();
    doReset();
    applyStimulus(1, 1, 1, 1);
    sDat = 32'hA5A5_0001;
    @(negedge clk);
    checkGrantBoth("t2.idle", 0);
    step();
    pushBoth(0, 1, 0, 0, 32'hA5A5_0001);
    @(negedge clk);
    checkGrantBoth("t2.first", 1);
    step();
    applyStimulus(0, 0, 1, 1);
    @(negedge clk);
    checkGrantBoth("t2.hold", 1);
    step();
    sDat = 32'hA5A5_0002;
    pushBoth(1, 1, 0, 0, 32'hA5A5_0002);
    @(negedge clk);
    checkGrantBoth("t2.handoff", 2);
    checkOutput("t2.we", 64'(sWe[0]), 64'h1);
    checkOutput("t2.wdat", 64'(sDatO[1]), 64'h2222_2222);
    checkOutput("t2.sel", 64'(sSel[0]), 64'h3);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    @(negedge clk);
    checkGrantBoth("t2.idle_end", 0);

    $display("[TB] alternating masters");
    for (int n = 0; n < 14; n++) begin
      step();
      applyStimulus(rrC0[n], rrC0[n], rrC1[n], rrC1[n]);
      sDat = 32'h5000_0000 + 32'(n);
      if (rrAck[n] >= 0) pushBoth(rrAck[n], 1, 0, 0, sDat);
      @(negedge clk);
      checkGrantBoth($sformatf("t3.n%0d", n), rrGnt[n]);
    end

    $display("[TB] tie after m0 was last granted");
    step();
    applyStimulus(1, 1, 0, 0);
    @(negedge clk);
    checkGrantBoth("t3b.idle", 0);
    step();
    sDat = 32'h7000_0001;
    pushBoth(0, 1, 0, 0, sDat);
    @(negedge clk);
    checkGrantBoth("t3b.m0", 1);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 1, 1);
    @(negedge clk);
    checkGrantBoth("t3b.idle2", 0);
    step();
    sDat = 32'h7000_0002;
    pushExp(0, 0, 1, 0, 0, sDat);
    pushExp(1, 1, 1, 0, 0, sDat);
    @(negedge clk);
    checkGrant("t3b.fixed", 0, 1);
    checkGrant("t3b.rr", 1, 2);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    @(negedge clk);
    checkGrantBoth("t3b.idle_end", 0);

    $display("[TB] locked multi-beat cycle");
    step();
    applyStimulus(1, 1, 1, 1);
    @(negedge clk);
    checkGrantBoth("t4.idle", 0);
    for (int b = 1; b <= 4; b++) begin
      step();
      sDat = 32'hB000_0000 + 32'(b);
      pushBoth(0, 1, 0, 0, sDat);
      @(negedge clk);
      checkGrantBoth($sformatf("t4.beat%0d", b), 1);
    end
    step();
    applyStimulus(0, 0, 1, 1);
    @(negedge clk);
    checkGrantBoth("t4.drop", 1);
    step();
    sDat = 32'hB000_0010;
    pushBoth(1, 1, 0, 0, sDat);
    @(negedge clk);
    checkGrantBoth("t4.m1", 2);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    @(negedge clk);
    checkGrantBoth("t4.idle_end", 0);

    $display("[TB] error and retry paths");
    step();
    applyStimulus(0, 0, 1, 1);
    sAck = 1'b0;
    sErr = 1'b1;
    sDat = 32'hE000_0001;
    step();
    pushBoth(1, 0, 1, 0, sDat);
    @(negedge clk);
    checkOutput("t5.m1err", 64'(m1ErrO[0]), 64'h1);
    checkOutput("t5.m0err", 64'(m0ErrO[1]), 64'h0);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 0, 0);
    sErr = 1'b0;
    sRty = 1'b1;
    sDat = 32'hE000_0002;
    step();
    pushBoth(0, 0, 0, 1, sDat);
    @(negedge clk);
    checkOutput("t5.m0rty", 64'(m0RtyO[1]), 64'h1);
    checkOutput("t5.m1rty", 64'(m1RtyO[0]), 64'h0);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    sRty = 1'b0;

    $display("[TB] reset during a write");
    step();
    applyStimulus(0, 0, 1, 1);
    m1We  = 1'b1;
    m1Dat = 32'hCAFE_F00D;
    sDat  = '0;
    @(negedge clk);
    checkGrantBoth("t6.idle", 0);
    step();
    @(negedge clk);
    checkOutput("t6.wdat", 64'(sDatO[0]), 64'hCAFE_F00D);
    checkOutput("t6.we", 64'(sWe[1]), 64'h1);
    checkCycBoth("t6.busy", 1'b1);
    #1;
    rst = 1'b1;
    #1;
    sAck = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("t6.rst_bus%0d", g), {sAdr[g], sDatO[g]}, 64'h0);
      checkOutput($sformatf("t6.rst_ctl%0d", g),
                  64'({sSel[g], sWe[g], sStb[g], sCyc[g], m0AckO[g], m1AckO[g]}), 64'h0);
    end
    step();
    rst = 1'b0;
    sDat = 32'h6000_0001;
    @(negedge clk);
    checkGrantBoth("t6.post_rst", 0);
    step();
    pushBoth(1, 1, 0, 0, 32'h6000_0001);
    @(negedge clk);
    checkGrantBoth("t6.regrant", 2);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    step();

    checkOutput("leftover0", 64'(expQ[0].size()), 64'h0);
    checkOutput("leftover1", 64'(expQ[1].size()), 64'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
